pio_ram_responder: RTL and testbench

- Memory-side end of the 2-pin serial RAM link that the video/compute core drives through `tx_pins` and `rx_pins`.
- Decodes read and write request frames arriving on `rx_pins`. Reads and writes are served from an internal synchronous RAM.
- Read data is returned as response frames on `tx_pins`.
- Used as an on-FPGA stand-in for the external RAM emulator: in simulation benches, and for builds without the RP2040 link.

---
 rtl/pio_ram_responder_if.sv | 8 +
 rtl/pio_ram_responder.sv | 162 ++++++++++++++++
 tb/tb_pio_ram_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_ram_responder_if.sv
// Serial RAM link pins between the core (master) and the memory-side responder (slave).
interface pio_ram_responder_if #(parameter int IO_BITS = 2);
  logic [IO_BITS-1:0] rx_pins;
  logic [IO_BITS-1:0] tx_pins;

  modport master (output rx_pins, input tx_pins);
  modport slave  (input rx_pins, output tx_pins);
endinterface

// File: rtl/pio_ram_responder.sv
// Memory-side end of the 2-pin serial RAM link: decodes read/write frames, serves them
// from an internal synchronous RAM and returns read data as response frames.
module pio_ram_responder #(
  parameter int IO_BITS       = 2,
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 16,
  parameter int MEM_ADDR_BITS = 8,
  parameter int RESP_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  pio_ram_responder_if.slave       link,
  input  logic                     init_we,
  input  logic [MEM_ADDR_BITS-1:0] init_addr,
  input  logic [DATA_BITS-1:0]     init_data,
  output logic                     overrun,
  output logic                     busy
);
  localparam int A  = ADDR_BITS / IO_BITS;
  localparam int D  = DATA_BITS / IO_BITS;
  localparam int CW = $clog2((A > D) ? A : D) + 1;
  localparam int LW = (RESP_LATENCY > 2) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [IO_BITS-1:0] START_RD = IO_BITS'(1);
  localparam logic [IO_BITS-1:0] START_WR = '1;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA} rx_state_t;

  rx_state_t              state;
  logic                   is_wr, armed;
  logic [CW-1:0]          rx_cnt;
  logic [ADDR_BITS-1:0]   addr_sr, addr_next;
  logic                   rd_issue, rd_vld;
  logic [MEM_ADDR_BITS-1:0] rd_addr, wr_addr;
  logic                   wr_commit;
  logic [DATA_BITS-1:0]   wr_data, ram_q;

  assign addr_next = {link.rx_pins, addr_sr[ADDR_BITS-1:IO_BITS]};

  // armed only rises on an all-zero idle, so a frame cut by reset cannot restart mid-stream
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      armed     <= 1'b0;
      rx_cnt    <= '0;
      addr_sr   <= '0;
      rd_issue  <= 1'b0;
      rd_addr   <= '0;
      wr_commit <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      rd_issue  <= 1'b0;
      wr_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (link.rx_pins == '0) armed <= 1'b1;
          else if (armed && (link.rx_pins == START_RD || link.rx_pins == START_WR)) begin
            state  <= ADDR;
            is_wr  <= (link.rx_pins == START_WR);
            rx_cnt <= '0;
          end
        end
        ADDR: begin
          addr_sr <= addr_next;
          rx_cnt  <= rx_cnt + CW'(1);
          if (rx_cnt == CW'(A - 1)) begin
            rx_cnt <= '0;
            if (is_wr) state <= WDATA;
            else begin
              state    <= IDLE;
              rd_issue <= 1'b1;
              rd_addr  <= addr_next[MEM_ADDR_BITS-1:0];
            end
          end
        end
        WDATA: begin
          wr_data <= {link.rx_pins, wr_data[DATA_BITS-1:IO_BITS]};
          rx_cnt  <= rx_cnt + CW'(1);
          if (rx_cnt == CW'(D - 1)) begin
            state     <= IDLE;
            wr_commit <= 1'b1;
            wr_addr   <= addr_sr[MEM_ADDR_BITS-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0]     mem [2**MEM_ADDR_BITS];
  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0]     mem_wdata;

  always_comb begin
    mem_we    = init_we | wr_commit;
    mem_waddr = init_we ? init_addr : wr_addr;
    mem_wdata = init_we ? init_data : wr_data;
  end

  // Write-first: a same-cycle write to the read address forwards the new word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q <= (mem_we && mem_waddr == rd_addr) ? mem_wdata : mem[rd_addr];
  end

  logic                 pend_vld, act_vld;
  logic [DATA_BITS-1:0] pend_data, act_data, eff_data;
  logic [LW-1:0]        pend_cnt, eff_cnt;
  logic [CW-1:0]        tx_cnt;
  logic                 eff_vld, tx_free, load;

  // Fresh RAM data is viewed as already pending so a minimal latency can launch it directly.
  always_comb begin
    eff_vld  = pend_vld | rd_vld;
    eff_data = pend_vld ? pend_data : ram_q;
    eff_cnt  = pend_vld ? pend_cnt : LW'(RESP_LATENCY - 3);
    tx_free  = !act_vld || tx_cnt == '0;
    load     = eff_vld && eff_cnt == '0 && tx_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld       <= 1'b0;
      pend_vld     <= 1'b0;
      pend_data    <= '0;
      pend_cnt     <= '0;
      act_vld      <= 1'b0;
      act_data     <= '0;
      tx_cnt       <= '0;
      link.tx_pins <= '0;
      overrun      <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_vld && pend_vld) overrun <= 1'b1;

      if (load) pend_vld <= 1'b0;
      else if (eff_vld) begin
        pend_vld  <= 1'b1;
        pend_data <= eff_data;
        pend_cnt  <= (eff_cnt == '0) ? eff_cnt : eff_cnt - LW'(1);
      end

      if (load) begin
        act_vld      <= 1'b1;
        act_data     <= eff_data;
        tx_cnt       <= CW'(D);
        link.tx_pins <= START_RD;
      end else if (act_vld && tx_cnt != '0) begin
        link.tx_pins <= act_data[IO_BITS-1:0];
        act_data     <= act_data >> IO_BITS;
        tx_cnt       <= tx_cnt - CW'(1);
      end else begin
        act_vld      <= 1'b0;
        link.tx_pins <= '0;
      end
    end
  end

  assign busy = (state != IDLE) | rd_issue | rd_vld | pend_vld | act_vld;
endmodule

// File: tb/tb_pio_ram_responder.sv
// Bench for pio_ram_responder: default instance plus a 32-bit-data instance for overrun.
module tb_pio_ram_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pio_ram_responder_if #(.IO_BITS(2)) l0 ();
  pio_ram_responder_if #(.IO_BITS(2)) l1 ();

  logic [1:0]  rx0 = '0, rx1 = '0;
  logic        init_we0 = 0, init_we1 = 0;
  logic [7:0]  init_addr0 = '0, init_addr1 = '0;
  logic [15:0] init_data0 = '0;
  logic [31:0] init_data1 = '0;
  logic        overrun0, overrun1, busy0, busy1;

  assign l0.rx_pins = rx0;
  assign l1.rx_pins = rx1;

  pio_ram_responder dut0 (
    .clk(clk), .reset(reset), .link(l0),
    .init_we(init_we0), .init_addr(init_addr0), .init_data(init_data0),
    .overrun(overrun0), .busy(busy0));

  pio_ram_responder #(.DATA_BITS(32)) dut1 (
    .clk(clk), .reset(reset), .link(l1),
    .init_we(init_we1), .init_addr(init_addr1), .init_data(init_data1),
    .overrun(overrun1), .busy(busy1));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          mon_cnt[2];
  logic [31:0] mon_word[2];
  int          frames[2];

  initial begin
    for (int k = 0; k < 2; k++) begin mon_cnt[k] = 0; mon_word[k] = '0; frames[k] = 0; end
  end

  // Scoreboard monitor: reassembles each response frame and pops the expected word.
  always @(negedge clk) begin
    logic [1:0]  t;
    int          dd;
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      t  = (k == 0) ? l0.tx_pins : l1.tx_pins;
      dd = (k == 0) ? 8 : 16;
      if (reset) mon_cnt[k] = 0;
      else if (mon_cnt[k] == 0) begin
        if (t == 2'd1) begin mon_cnt[k] = dd; mon_word[k] = '0; end
        else if (t != 2'd0) begin
          vectors++; miscompares++;
          $display("FAIL idle%0d: tx=%0d between frames, want 0 or 1", k, t);
        end
      end else begin
        mon_word[k][2*(dd-mon_cnt[k]) +: 2] = t;
        mon_cnt[k]--;
        if (mon_cnt[k] == 0) begin
          frames[k]++;
          vectors++;
          if ((k == 0) ? (exp0.size() == 0) : (exp1.size() == 0)) begin
            miscompares++;
            $display("FAIL resp%0d: unexpected frame %h, want none", k, mon_word[k]);
          end else begin
            e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
            if (mon_word[k] !== e) begin
              miscompares++;
              $display("FAIL resp%0d: got %h, want %h", k, mon_word[k], e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int sel, input logic [1:0] v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic preload(input int sel, input logic [7:0] a, input logic [31:0] d);
    if (sel == 0) begin init_we0 = 1; init_addr0 = a; init_data0 = d[15:0]; end
    else begin init_we1 = 1; init_addr1 = a; init_data1 = d; end
    tick();
    init_we0 = 0; init_we1 = 0;
  endtask

  task automatic send(input int sel, input logic [1:0] start, input logic [15:0] addr,
                      input logic [31:0] data);
    int d = (sel == 0) ? 8 : 16;
    drive(sel, start); tick();
    for (int i = 0; i < 8; i++) begin drive(sel, addr[2*i +: 2]); tick(); end
    if (start == 2'd3)
      for (int i = 0; i < d; i++) begin drive(sel, data[2*i +: 2]); tick(); end
    drive(sel, 2'd0);
  endtask

  task automatic wait_idle(input int sel, input string name);
    int n = 0;
    while (((sel == 0) ? busy0 : busy1) || mon_cnt[sel] != 0) begin
      if (n >= 300) break;
      tick(); n++;
    end
    vectors++;
    if (n >= 300) begin miscompares++; $display("FAIL %s: still busy after %0d cycles, want idle", name, n); end
    tick(); tick();
    vectors++;
    if (((sel == 0) ? exp0.size() : exp1.size()) != 0) begin
      miscompares++;
      $display("FAIL %s: %0d responses missing, want 0", name, (sel == 0) ? exp0.size() : exp1.size());
    end
  endtask

  task automatic test_reset();
    reset = 1;
    preload(0, 8'h12, 32'hBEEF);
    preload(1, 8'h20, 32'hDEADBEEF);
    preload(1, 8'h21, 32'h01234567);
    preload(1, 8'h22, 32'h89ABCDEF);
    vectors++;
    if ({l0.tx_pins, busy0, overrun0, l1.tx_pins, busy1, overrun1} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: tx0=%0d busy0=%b ovr0=%b tx1=%0d busy1=%b ovr1=%b, want all 0",
               l0.tx_pins, busy0, overrun0, l1.tx_pins, busy1, overrun1);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_read();
    exp0.push_back(32'hBEEF);
    send(0, 2'd1, 16'h0012, 0);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (l0.tx_pins !== 2'd0) begin miscompares++; $display("FAIL read_lat: tx=%0d at L+%0d, want 0", l0.tx_pins, c); end
      tick();
    end
    vectors++;
    if (l0.tx_pins !== 2'd1) begin miscompares++; $display("FAIL read_start: tx=%0d at L+4, want 1", l0.tx_pins); end
    repeat (8) tick();
    vectors++;
    if (busy0 !== 1'b1) begin miscompares++; $display("FAIL read_busy_last: busy=%b, want 1", busy0); end
    tick();
    vectors++;
    if (busy0 !== 1'b0 || l0.tx_pins !== 2'd0) begin
      miscompares++; $display("FAIL read_end: busy=%b tx=%0d, want 0 0", busy0, l0.tx_pins);
    end
    wait_idle(0, "read");
  endtask

  task automatic test_write_read();
    exp0.push_back(32'h1234);
    send(0, 2'd3, 16'h0034, 32'h1234);
    send(0, 2'd1, 16'h0034, 0);
    wait_idle(0, "write_read");
  endtask

  task automatic test_alias();
    exp0.push_back(32'hBEEF);
    send(0, 2'd1, 16'h0112, 0);
    wait_idle(0, "alias");
  endtask

  task automatic test_reserved();
    int f = frames[0];
    drive(0, 2'd2);
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (busy0 !== 1'b0 || l0.tx_pins !== 2'd0) begin
        miscompares++; $display("FAIL reserved: busy=%b tx=%0d at cycle %0d, want 0 0", busy0, l0.tx_pins, c);
      end
    end
    drive(0, 2'd0);
    repeat (6) tick();
    vectors++;
    if (frames[0] != f) begin miscompares++; $display("FAIL reserved_frames: %0d frames, want %0d", frames[0], f); end
    exp0.push_back(32'hBEEF);
    exp0.push_back(32'h1234);
    send(0, 2'd1, 16'h0012, 0);
    send(0, 2'd1, 16'h0034, 0);
    wait_idle(0, "reserved_ram");
  endtask

  task automatic test_overrun();
    int f = frames[1];
    exp1.push_back(32'hDEADBEEF);
    exp1.push_back(32'h01234567);
    send(1, 2'd1, 16'h0020, 0);
    send(1, 2'd1, 16'h0021, 0);
    send(1, 2'd1, 16'h0022, 0);
    tick(); tick();
    vectors++;
    if (l1.tx_pins !== 2'd1) begin miscompares++; $display("FAIL overrun_contig: tx=%0d at 2nd start, want 1", l1.tx_pins); end
    wait_idle(1, "overrun");
    vectors++;
    if (frames[1] - f != 2) begin miscompares++; $display("FAIL overrun_frames: %0d frames, want 2", frames[1] - f); end
    vectors++;
    if (overrun1 !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: overrun=%b, want 1", overrun1); end
    exp1.push_back(32'h89ABCDEF);
    send(1, 2'd1, 16'h0022, 0);
    wait_idle(1, "overrun_after");
    vectors++;
    if (overrun1 !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: overrun=%b, want 1", overrun1); end
  endtask

  task automatic test_reset_mid();
    exp0.push_back(32'hBEEF);
    send(0, 2'd1, 16'h0012, 0);
    repeat (6) tick();
    reset = 1;
    exp0.delete();
    tick();
    vectors++;
    if ({l0.tx_pins, busy0, overrun0, overrun1} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid: tx=%0d busy=%b ovr0=%b ovr1=%b, want all 0", l0.tx_pins, busy0, overrun0, overrun1);
    end
    reset = 0;
    tick();
    exp0.push_back(32'hBEEF);
    send(0, 2'd1, 16'h0012, 0);
    wait_idle(0, "reset_mid_read");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_alias();
    test_reserved();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
